// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubbles.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [3:0]         in_alu_op,
    input  logic               in_alu_src_imm,
    input  logic               in_alu_src_pc,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_mem_to_reg,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic               exm_reg_write,
    input  logic [XLEN-1:0]    exm_result,
    input  logic [RADDR_W-1:0] mwb_rd,
    input  logic               mwb_reg_write,
    input  logic [XLEN-1:0]    mwb_result,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [3:0]         alu_op,
    output logic [XLEN-1:0]    store_data,
    output logic [RADDR_W-1:0] ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_valid,
    output logic               load_use,
    output logic [XLEN-1:0]    bubble_count
);

    typedef struct packed {
        logic               valid;
        logic [RADDR_W-1:0] rd;
        logic [3:0]         alu_op;
        logic               src_imm;
        logic               src_pc;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
    } data_t;

    ctrl_t ctrl_q;
    ctrl_t ctrl_d;
    data_t data_q;
    data_t data_d;
    logic  capture;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use = ctrl_q.valid & ctrl_q.mem_read
                    & (ctrl_q.rd != '0) & in_valid
                    & ((in_rs1_addr == ctrl_q.rd)
                     | (in_rs2_addr == ctrl_q.rd));

    assign capture = ~flush & ~stall & ~load_use;

    assign ctrl_d = '{
        valid:      in_valid,
        rd:         in_rd_addr,
        alu_op:     in_alu_op,
        src_imm:    in_alu_src_imm,
        src_pc:     in_alu_src_pc,
        reg_write:  in_reg_write,
        mem_read:   in_mem_read,
        mem_write:  in_mem_write,
        mem_to_reg: in_mem_to_reg
    };

    assign data_d = '{
        pc:       in_pc,
        rs1_data: in_rs1_data,
        rs2_data: in_rs2_data,
        imm:      in_imm,
        rs1:      in_rs1_addr,
        rs2:      in_rs2_addr
    };

    // Control register: flush beats stall, load-use bubbles when not stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
        end else if (!stall) begin
            if (load_use) begin
                ctrl_q <= '0;
            end else begin
                ctrl_q <= ctrl_d;
            end
        end
    end

    // Data register only moves on a real capture; bubbles leave it stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (capture) begin
            data_q <= data_d;
        end
    end

    // Forward rs1: EX/MEM has priority over MEM/WB, x0 never forwarded.
    always_comb begin
        fwd_rs1 = data_q.rs1_data;
        if (exm_reg_write && exm_rd != '0 && exm_rd == data_q.rs1) begin
            fwd_rs1 = exm_result;
        end else if (mwb_reg_write && mwb_rd != '0
                     && mwb_rd == data_q.rs1) begin
            fwd_rs1 = mwb_result;
        end
    end

    // Forward rs2 with the same priority rules.
    always_comb begin
        fwd_rs2 = data_q.rs2_data;
        if (exm_reg_write && exm_rd != '0 && exm_rd == data_q.rs2) begin
            fwd_rs2 = exm_result;
        end else if (mwb_reg_write && mwb_rd != '0
                     && mwb_rd == data_q.rs2) begin
            fwd_rs2 = mwb_result;
        end
    end

    assign alu_a         = ctrl_q.src_pc  ? data_q.pc  : fwd_rs1;
    assign alu_b         = ctrl_q.src_imm ? data_q.imm : fwd_rs2;
    assign store_data    = fwd_rs2;
    assign alu_op        = ctrl_q.alu_op;
    assign ex_rd         = ctrl_q.rd;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic            bubble_ld;
    logic [XLEN-1:0] bubble_q;

    assign bubble_ld = flush | (~stall & load_use);

    // Count every edge that loads a bubble; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
        end else if (bubble_ld) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

    assign bubble_count = bubble_q;
`else
    assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, corner sequences,
// and randomized traffic against a behavioural pipeline-slot model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, in_valid;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [3:0]  in_alu_op;
    logic        in_alu_src_imm, in_alu_src_pc;
    logic        in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] alu_a, alu_b, store_data, bubble_count;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_mem_to_reg, ex_valid, load_use;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_rs1_addr(in_rs1_addr),
        .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_alu_op(in_alu_op), .in_alu_src_imm(in_alu_src_imm),
        .in_alu_src_pc(in_alu_src_pc), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write),
        .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write),
        .mwb_result(mwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .store_data(store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_valid(ex_valid), .load_use(load_use),
        .bubble_count(bubble_count)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(int n);
`ifdef ID_EX_BUBBLE_CNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    task automatic clr_ins();
        in_valid = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
        in_alu_op = 0; in_alu_src_imm = 0; in_alu_src_pc = 0;
        in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        in_mem_to_reg = 0;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
        stall = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clr_ins();
        @(negedge clk);
        rst = 0;
    endtask

    // Vector table for the forwarding / operand-select paths
    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] r1d, r2d;
        logic        simm, spc;
        logic [31:0] pc, imm;
        logic [4:0]  erd;
        logic        erw;
        logic [31:0] eres;
        logic [4:0]  mrd;
        logic        mrw;
        logic [31:0] mres;
        logic [31:0] ea, eb, esd;
    } vec_t;

    vec_t tbl[9];

    // Behavioural model: one EX pipeline slot
    typedef struct {
        bit          v, dk;
        logic [31:0] pc, r1d, r2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        bit          simm, spc, rw, mr, mw, m2r;
    } slot_t;

    slot_t m;
    int    mcnt;

    function automatic bit model_lu();
        return m.v && m.mr && m.rd != 0 && in_valid
            && (in_rs1_addr == m.rd || in_rs2_addr == m.rd);
    endfunction

    function automatic logic [31:0] fwd(logic [4:0] a, logic [31:0] d);
        if (exm_reg_write && exm_rd != 0 && exm_rd == a)
            return exm_result;
        if (mwb_reg_write && mwb_rd != 0 && mwb_rd == a)
            return mwb_result;
        return d;
    endfunction

    task automatic chk_model(string t);
        chk({t, ".valid"}, 32'(ex_valid), 32'(m.v));
        chk({t, ".rd"}, 32'(ex_rd), 32'(m.rd));
        chk({t, ".op"}, 32'(alu_op), 32'(m.op));
        chk({t, ".ctl"},
            {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, m.rw, m.mr, m.mw, m.m2r});
        chk({t, ".lu"}, 32'(load_use), 32'(model_lu()));
        chk({t, ".cnt"}, bubble_count, cnt_exp(mcnt));
        if (m.dk) begin
            chk({t, ".a"}, alu_a, m.spc ? m.pc : fwd(m.rs1, m.r1d));
            chk({t, ".b"}, alu_b, m.simm ? m.imm : fwd(m.rs2, m.r2d));
            chk({t, ".sd"}, store_data, fwd(m.rs2, m.r2d));
        end
    endtask

    task automatic model_tick();
        bit lu;
        lu = model_lu();
        @(posedge clk);
        if (flush || (!stall && lu)) begin
            m.v = 0; m.rd = 0; m.op = 0; m.simm = 0; m.spc = 0;
            m.rw = 0; m.mr = 0; m.mw = 0; m.m2r = 0; m.dk = 0;
            mcnt++;
        end else if (!stall) begin
            m.v = in_valid; m.pc = in_pc; m.r1d = in_rs1_data;
            m.r2d = in_rs2_data; m.imm = in_imm;
            m.rs1 = in_rs1_addr; m.rs2 = in_rs2_addr;
            m.rd = in_rd_addr; m.op = in_alu_op;
            m.simm = in_alu_src_imm; m.spc = in_alu_src_pc;
            m.rw = in_reg_write; m.mr = in_mem_read;
            m.mw = in_mem_write; m.m2r = in_mem_to_reg; m.dk = 1;
        end
        #1;
    endtask

    task automatic rand_ins();
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_pc = $urandom; in_rs1_data = $urandom;
        in_rs2_data = $urandom; in_imm = $urandom;
        in_rs1_addr = 5'($urandom_range(0, 7));
        in_rs2_addr = 5'($urandom_range(0, 7));
        in_rd_addr = 5'($urandom_range(0, 7));
        in_alu_op = 4'($urandom_range(0, 8));
        in_alu_src_imm = 1'($urandom); in_alu_src_pc = 1'($urandom);
        in_reg_write = 1'($urandom);
        in_mem_read = 1'($urandom_range(0, 2) == 0);
        in_mem_write = 1'($urandom); in_mem_to_reg = 1'($urandom);
        exm_rd = 5'($urandom_range(0, 7));
        exm_reg_write = 1'($urandom); exm_result = $urandom;
        mwb_rd = 5'($urandom_range(0, 7));
        mwb_reg_write = 1'($urandom); mwb_result = $urandom;
        stall = 1'($urandom_range(0, 7) == 0);
        flush = 1'($urandom_range(0, 9) == 0);
    endtask

    initial begin
        tbl[0] = '{5'd3, 5'd7, 32'h11, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd3, 1'b1, 32'hAA, 5'd3, 1'b1, 32'hBB,
                   32'hAA, 32'h22, 32'h22};
        tbl[1] = '{5'd3, 5'd7, 32'h11, 32'h22, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd3, 1'b0, 32'hAA, 5'd3, 1'b1, 32'hBB,
                   32'hBB, 32'h22, 32'h22};
        tbl[2] = '{5'd1, 5'd0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd0, 1'b1, 32'h55, 5'd0, 1'b1, 32'h66,
                   32'h10, 32'h0, 32'h0};
        tbl[3] = '{5'd2, 5'd9, 32'h20, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd8, 1'b1, 32'h88, 5'd9, 1'b1, 32'h99,
                   32'h20, 32'h99, 32'h99};
        tbl[4] = '{5'd2, 5'd9, 32'h20, 32'h30, 1'b1, 1'b0, 32'h0, 32'h123,
                   5'd9, 1'b1, 32'h77, 5'd0, 1'b0, 32'h0,
                   32'h20, 32'h123, 32'h77};
        tbl[5] = '{5'd3, 5'd7, 32'h11, 32'h22, 1'b0, 1'b1, 32'h400, 32'h0,
                   5'd3, 1'b1, 32'hAA, 5'd0, 1'b0, 32'h0,
                   32'h400, 32'h22, 32'h22};
        tbl[6] = '{5'd6, 5'd6, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd6, 1'b1, 32'hC, 5'd6, 1'b1, 32'hD,
                   32'hC, 32'hC, 32'hC};
        tbl[7] = '{5'd6, 5'd6, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd6, 1'b0, 32'hC, 5'd6, 1'b1, 32'hD,
                   32'hD, 32'hD, 32'hD};
        tbl[8] = '{5'd5, 5'd4, 32'h1, 32'h2, 1'b0, 1'b0, 32'h0, 32'h0,
                   5'd5, 1'b0, 32'hE, 5'd4, 1'b0, 32'hF,
                   32'h1, 32'h2, 32'h2};

        rst = 1;
        clr_ins();
        #12;
        // Reset state
        chk("rst.valid", 32'(ex_valid), 0);
        chk("rst.ctl", {27'd0, ex_reg_write, ex_mem_read, ex_mem_write,
                        ex_mem_to_reg, load_use}, 0);
        chk("rst.op", 32'(alu_op), 0);
        chk("rst.rd", 32'(ex_rd), 0);
        chk("rst.a", alu_a, 0);
        chk("rst.b", alu_b, 0);
        chk("rst.sd", store_data, 0);
        chk("rst.cnt", bubble_count, 0);
        @(negedge clk);
        rst = 0;

        // First capture
        in_valid = 1; in_pc = 32'h100; in_rs1_addr = 1; in_rs2_addr = 2;
        in_rs1_data = 5; in_rs2_data = 7; in_alu_op = 0;
        tick();
        chk("cap.valid", 32'(ex_valid), 1);
        chk("cap.a", alu_a, 5);
        chk("cap.b", alu_b, 7);

        // Forwarding table
        foreach (tbl[i]) begin
            @(negedge clk);
            clr_ins();
            in_valid = 1;
            in_rs1_addr = tbl[i].rs1; in_rs2_addr = tbl[i].rs2;
            in_rs1_data = tbl[i].r1d; in_rs2_data = tbl[i].r2d;
            in_alu_src_imm = tbl[i].simm; in_alu_src_pc = tbl[i].spc;
            in_pc = tbl[i].pc; in_imm = tbl[i].imm;
            tick();
            exm_rd = tbl[i].erd; exm_reg_write = tbl[i].erw;
            exm_result = tbl[i].eres;
            mwb_rd = tbl[i].mrd; mwb_reg_write = tbl[i].mrw;
            mwb_result = tbl[i].mres;
            #1;
            chk($sformatf("tbl%0d.a", i), alu_a, tbl[i].ea);
            chk($sformatf("tbl%0d.b", i), alu_b, tbl[i].eb);
            chk($sformatf("tbl%0d.sd", i), store_data, tbl[i].esd);
        end

        // Load-use: lw x4 then add x5,x4,x1
        @(negedge clk);
        clr_ins();
        in_valid = 1; in_rd_addr = 4; in_rs1_addr = 2;
        in_mem_read = 1; in_reg_write = 1; in_mem_to_reg = 1;
        tick();
        chk("lw.mr", 32'(ex_mem_read), 1);
        @(negedge clk);
        clr_ins();
        in_valid = 1; in_rd_addr = 5; in_rs1_addr = 4; in_rs2_addr = 1;
        in_reg_write = 1;
        #1;
        chk("lu.hit", 32'(load_use), 1);
        tick();
        chk("lu.bub_valid", 32'(ex_valid), 0);
        chk("lu.bub_rd", 32'(ex_rd), 0);
        chk("lu.clear", 32'(load_use), 0);
        tick();
        chk("lu.add_valid", 32'(ex_valid), 1);
        chk("lu.add_rd", 32'(ex_rd), 5);
        chk("lu.cnt", bubble_count, cnt_exp(1));

        // Stall holds, then stall+flush bubbles
        @(negedge clk);
        clr_ins();
        in_valid = 1; in_pc = 32'h200; in_rs1_addr = 1;
        in_rs1_data = 32'h31; in_rd_addr = 9; in_alu_op = 3;
        in_reg_write = 1;
        tick();
        chk("st.rd0", 32'(ex_rd), 9);
        @(negedge clk);
        stall = 1; in_rd_addr = 12; in_alu_op = 5; in_rs1_data = 32'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("st%0d.rd", k), 32'(ex_rd), 9);
            chk($sformatf("st%0d.op", k), 32'(alu_op), 3);
            chk($sformatf("st%0d.a", k), alu_a, 32'h31);
            chk($sformatf("st%0d.v", k), 32'(ex_valid), 1);
        end
        @(negedge clk);
        flush = 1;
        tick();
        chk("sf.valid", 32'(ex_valid), 0);
        chk("sf.rw", 32'(ex_reg_write), 0);
        chk("sf.rd", 32'(ex_rd), 0);
        chk("sf.cnt", bubble_count, cnt_exp(2));

        // Async reset mid-cycle
        @(negedge clk);
        clr_ins();
        in_valid = 1; in_rd_addr = 3; in_alu_op = 2; in_reg_write = 1;
        tick();
        chk("ar.pre", 32'(ex_valid), 1);
        #2;
        rst = 1;
        #1;
        chk("ar.valid", 32'(ex_valid), 0);
        chk("ar.op", 32'(alu_op), 0);
        chk("ar.cnt", bubble_count, 0);
        @(negedge clk);
        rst = 0;

        // Randomized traffic against the slot model
        do_reset();
        m = '{default: 0};
        m.dk = 1;
        mcnt = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rand_ins();
            #1;
            chk_model($sformatf("r%0d.pre", n));
            model_tick();
            chk_model($sformatf("r%0d.post", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage RV32I pipeline. It sits directly upstream of the ALU and drives its a, b and alu_op inputs. It also detects load-use hazards and inserts bubbles, and passes memory and writeback control down to EX/MEM.

Parameters:
XLEN, 32, datapath width (only 32 is supported)
RADDR_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
stall  in  1  hold all stage registers (downstream memory wait)
flush  in  1  load a bubble (branch/jump redirect)
in_valid  in  1  decode stage holds a valid instruction
in_pc  in  32  instruction PC
in_rs1_data / in_rs2_data  in  32 each  register file read data
in_imm  in  32  sign-extended immediate
in_rs1_addr / in_rs2_addr / in_rd_addr  in  5 each  register addresses
in_alu_op  in  4  ALU code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt)
in_alu_src_imm / in_alu_src_pc  in  1 each  operand B = imm / operand A = pc
in_reg_write / in_mem_read / in_mem_write / in_mem_to_reg  in  1 each  control
exm_rd  in  5; exm_reg_write  in  1; exm_result  in  32  EX/MEM forward source
mwb_rd  in  5; mwb_reg_write  in  1; mwb_result  in  32  MEM/WB forward source
alu_a / alu_b  out  32 each  ALU operands
alu_op  out  4  registered ALU code
store_data  out  32  forwarded rs2 for stores
ex_rd  out  5; ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid  out  1 each
load_use  out  1  hold IF/ID this cycle
bubble_count  out  32  inserted-bubble counter (see Optional Feature)

Behaviour:
- Reset (async, immediate): every stage register cleared to 0. Therefore ex_valid=0, all control outputs 0, alu_op=0, ex_rd=0; alu_a, alu_b and store_data evaluate to 0 unless a forward source is active.
- load_use (combinational) = ex_valid & ex_mem_read & ex_rd!=0 & in_valid & (in_rs1_addr==ex_rd | in_rs2_addr==ex_rd).
- Register update on each rising clk edge, by priority:
  1. flush=1: load a bubble.
  2. else stall=1: hold all registers.
  3. else load_use=1: load a bubble.
  4. else: capture all in_* inputs; ex_valid <= in_valid.
- Bubble contents: ex_valid=0, ex_rd=0, alu_op=0, all control bits 0. Data registers may take any value.
- Forwarding (combinational, from registered rs addresses):
  - fwd_rs1 = exm_result if exm_reg_write & exm_rd!=0 & exm_rd==rs1_q.
  - else fwd_rs1 = mwb_result if mwb_reg_write & mwb_rd!=0 & mwb_rd==rs1_q.
  - else fwd_rs1 = rs1_data_q.
  - fwd_rs2 is computed the same way. EX/MEM always wins over MEM/WB. x0 is never forwarded.
- Operand select: alu_a = alu_src_pc_q ? pc_q : fwd_rs1. alu_b = alu_src_imm_q ? imm_q : fwd_rs2. store_data = fwd_rs2, regardless of alu_src_imm.
- Latency: one cycle from in_* inputs to the registered outputs. Forwarded operands are valid in the same cycle the forward sources are presented.
- load_use is asserted for exactly one cycle per load-use pair. The bubble clears the condition on the following cycle.
- Rules: stall is asserted only when the whole pipeline freezes. Flush during stall still bubbles. Reset mid-stall clears everything.

Optional Feature:
Macro ID_EX_BUBBLE_CNT_EN.
- Defined: bubble_count increments by 1 on every clock edge on which a bubble is loaded (flush, or load_use without stall). It wraps from 0xFFFFFFFF to 0 and is cleared by rst.
- Undefined: no counter logic is built and bubble_count is tied to 0.

Test Plan:
- Reset then release: all outputs 0, ex_valid=0. Capture pc=0x100, alu_op=0, rs1=5, rs2=7 -> next cycle alu_a=5, alu_b=7, ex_valid=1.
- EX/MEM forward: rs1_q=3; exm_rd=3, exm_reg_write=1, exm_result=0xAA; mwb_rd=3, mwb_result=0xBB -> alu_a=0xAA. Set exm_reg_write=0 -> alu_a=0xBB.
- x0 guard: rs2_q=0, exm_rd=0, exm_reg_write=1, exm_result=0x55, rs2_data_q=0 -> alu_b=0 and store_data=0.
- Load-use: registered lw writing x4; decode add x5,x4,x1 -> load_use=1 for one cycle, next ex_valid=0; following cycle the add is captured and bubble_count=1 when ID_EX_BUBBLE_CNT_EN is defined.
- Stall/flush priority: stall=1 for 3 cycles -> outputs held constant. stall=1 with flush=1 -> bubble loaded, ex_reg_write=0.
- Async reset asserted mid-cycle while ex_valid=1 -> ex_valid=0 immediately, before the next clk edge.
